// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port IF/LS memory arbiter.
// Port encoding doubles as the bit index into per-port request/grant vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    localparam int NUM_PORTS = 2;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick. The last-grant register only moves when the
// caller pulses advance, so a held losing request wins the next round.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic                 any_req,
    output port_e                winner
);

    port_e last_reg;
    port_e last_next;

    always_comb begin
        any_req = |req;
        winner  = PORT_IF;
        if (req[PORT_LS] && !req[PORT_IF]) begin
            winner = PORT_LS;
        end else if (req[PORT_LS] && req[PORT_IF]) begin
            // Tie: the port that did not win last time goes first.
            winner = (last_reg == PORT_IF) ? PORT_LS : PORT_IF;
        end
    end

    always_comb begin
        last_next = last_reg;
        if (advance && any_req) begin
            last_next = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg <= PORT_LS;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one unified data memory between instruction fetch and load/store.
// One access per IDLE -> ACCESS -> RESP pass; misaligned accesses never write.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    // instruction fetch port (read only)
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    // load/store port
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    // memory side
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e state_reg, state_next;

    port_e         port_reg, port_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          we_reg, we_next;
    logic [DW-1:0] wdata_reg, wdata_next;

    logic [DW-1:0] rdata_reg, rdata_next;
    logic          err_reg, err_next;

    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] gnt_vec;
    logic [NUM_PORTS-1:0] rvalid_vec;
    logic                 any_req;
    port_e                winner;
    logic                 accept;
    logic                 aligned;

    assign req_vec = {ls_req, if_req};
    assign accept  = (state_reg == IDLE) && any_req;
    assign aligned = is_aligned(addr_reg[1:0]);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_vec),
        .advance (accept),
        .any_req (any_req),
        .winner  (winner)
    );

    // State transitions and all memory-side / handshake outputs.
    always_comb begin
        state_next = state_reg;
        gnt_vec    = '0;
        rvalid_vec = '0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                gnt_vec[port_reg] = 1'b1;
                mem_addr          = addr_reg;
                mem_wdata         = wdata_reg;
                // Reset in this cycle must not let a write commit at the edge.
                mem_we            = we_reg & aligned & ~reset;
                state_next        = RESP;
            end
            RESP: begin
                rvalid_vec[port_reg] = 1'b1;
                state_next           = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch: IF is forced to a read with zero write data.
    always_comb begin
        port_next  = port_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        wdata_next = wdata_reg;
        if (accept) begin
            port_next = winner;
            if (winner == PORT_IF) begin
                addr_next  = if_addr;
                we_next    = 1'b0;
                wdata_next = '0;
            end else begin
                addr_next  = ls_addr;
                we_next    = ls_we;
                wdata_next = ls_wdata;
            end
        end
    end

    // Response capture during ACCESS; writes and misaligned accesses return 0.
    always_comb begin
        rdata_next = rdata_reg;
        err_next   = err_reg;
        if (state_reg == ACCESS) begin
            rdata_next = (we_reg || !aligned) ? '0 : mem_rdata;
            err_next   = ~aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            port_reg  <= PORT_LS;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            port_reg  <= port_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Per-port response fan-out: only the port owning rvalid sees data/err.
    logic [DW-1:0]        port_rdata [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_rdata[gi] = rvalid_vec[gi] ? rdata_reg : '0;
            assign port_err[gi]   = rvalid_vec[gi] & err_reg;
        end
    endgenerate

    assign if_gnt    = gnt_vec[PORT_IF];
    assign if_rvalid = rvalid_vec[PORT_IF];
    assign if_rdata  = port_rdata[PORT_IF];
    assign if_err    = port_err[PORT_IF];

    assign ls_gnt    = gnt_vec[PORT_LS];
    assign ls_rvalid = rvalid_vec[PORT_LS];
    assign ls_rdata  = port_rdata[PORT_LS];
    assign ls_err    = port_err[PORT_LS];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------- environment memory (64 words) ----------------
    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'hDEADBEEF;
        if (i == 8) return 32'hCAFEF00D;
        return 32'hA5000000 | 32'(i);
    endfunction

    logic        tb_init;
    logic [31:0] mem [64];
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model + per-cycle compare ----------------
    logic [31:0] ref_mem [64];
    bit          m_busy = 1'b0;
    int          m_acc  = 0;
    bit          m_port = 1'b0;
    bit          m_last = 1'b1;      // 1 = LS granted last
    bit          m_we   = 1'b0;
    bit          m_err  = 1'b0;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int gnt_port_q[$];
    int gnt_cyc_q[$];
    int we_count = 0;
    logic [31:0] last_we_addr = 32'h0;

    bit [1:0]    e_gnt, e_rv;
    logic [31:0] e_rdata, e_addr, e_wdata;
    bit          e_err, e_we;

    initial begin : model_cmp
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_gnt = 2'b00; e_rv = 2'b00; e_rdata = 32'h0; e_err = 1'b0;
                e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
                if (m_busy && cyc == m_acc + 1) begin
                    e_gnt[m_port] = 1'b1;
                    e_addr  = m_addr;
                    e_wdata = m_wdata;
                    e_we    = m_we && !m_err && !reset;
                    if (e_we) ref_mem[m_addr[7:2]] = m_wdata;
                end
                if (m_busy && cyc == m_acc + 2) begin
                    e_rv[m_port] = 1'b1;
                    e_rdata = m_rdata;
                    e_err   = m_err;
                end
                check("if_gnt",    32'(if_gnt),    32'(e_gnt[0]));
                check("ls_gnt",    32'(ls_gnt),    32'(e_gnt[1]));
                check("if_rvalid", 32'(if_rvalid), 32'(e_rv[0]));
                check("ls_rvalid", 32'(ls_rvalid), 32'(e_rv[1]));
                check("if_rdata",  if_rdata,  e_rv[0] ? e_rdata : 32'h0);
                check("ls_rdata",  ls_rdata,  e_rv[1] ? e_rdata : 32'h0);
                check("if_err",    32'(if_err),    32'(e_rv[0] & e_err));
                check("ls_err",    32'(ls_err),    32'(e_rv[1] & e_err));
                check("mem_we",    32'(mem_we),    32'(e_we));
                check("mem_addr",  mem_addr,  e_addr);
                check("mem_wdata", mem_wdata, e_wdata);

                if (if_gnt) begin gnt_port_q.push_back(0); gnt_cyc_q.push_back(cyc); end
                if (ls_gnt) begin gnt_port_q.push_back(1); gnt_cyc_q.push_back(cyc); end
                if (mem_we) begin we_count++; last_we_addr = mem_addr; end

                if (reset) begin
                    m_busy = 1'b0;
                    m_last = 1'b1;
                end else if (m_busy && cyc == m_acc + 2) begin
                    m_busy = 1'b0;
                end else if (!m_busy && (if_req || ls_req)) begin
                    if (if_req && ls_req) m_port = !m_last;
                    else                  m_port = ls_req;
                    m_last = m_port;
                    m_busy = 1'b1;
                    m_acc  = cyc;
                    if (m_port == 1'b0) begin
                        m_addr = if_addr; m_we = 1'b0; m_wdata = 32'h0;
                    end else begin
                        m_addr = ls_addr; m_we = ls_we; m_wdata = ls_wdata;
                    end
                    m_err   = (m_addr[1:0] != 2'b00);
                    m_rdata = (m_we || m_err) ? 32'h0 : ref_mem[m_addr[7:2]];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int gnt_lat, output int rv_lat);
        int  t0, tg;
        bit  got_g, got_r;
        if (port == 1'b0) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end
        t0 = cyc; tg = cyc; got_g = 1'b0; got_r = 1'b0;
        rdata = 32'hX; err = 1'bX;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((port == 1'b0 && if_gnt) || (port == 1'b1 && ls_gnt)) begin
                got_g = 1'b1; tg = cyc; break;
            end
            tick();
        end
        check("gnt_seen", 32'(got_g), 32'd1);
        gnt_lat = tg - t0;
        tick();
        if_req = 1'b0; ls_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if ((port == 1'b0 && if_rvalid) || (port == 1'b1 && ls_rvalid)) begin
                got_r = 1'b1;
                rdata = port ? ls_rdata : if_rdata;
                err   = port ? ls_err : if_err;
                break;
            end
            tick();
        end
        check("rvalid_seen", 32'(got_r), 32'd1);
        rv_lat = cyc - tg;
        tick();
        $display("txn port=%s we=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d gnt_lat=%0d rv_lat=%0d",
                 port ? "LS" : "IF", we, addr, wdata, rdata, err, gnt_lat, rv_lat);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : directed
        logic [31:0] rd;
        logic        er;
        int          gl, rl, we0, s, r0;

        reset = 1'b1; tb_init = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        repeat (3) tick();
        tb_init = 1'b0;
        chk_en  = 1'b1;
        @(negedge clk);
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // IF-only read of word 0x8
        do_req(1'b0, 1'b0, 32'h8, 32'h0, rd, er, gl, rl);
        check("t1_if_rdata", rd, 32'hDEADBEEF);
        check("t1_if_err", 32'(er), 32'd0);
        check("t1_gnt_lat", 32'(gl), 32'd1);
        check("t1_rv_lat", 32'(rl), 32'd1);

        // LS write then read back
        we0 = we_count;
        do_req(1'b1, 1'b1, 32'h10, 32'h12345678, rd, er, gl, rl);
        check("t2_wr_rdata", rd, 32'h0);
        check("t2_wr_err", 32'(er), 32'd0);
        check("t2_we_pulses", 32'(we_count - we0), 32'd1);
        check("t2_we_addr", last_we_addr, 32'h10);
        check("t2_mem_word", mem[4], 32'h12345678);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, rd, er, gl, rl);
        check("t2_rd_rdata", rd, 32'h12345678);

        // Both ports requesting continuously from reset
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        tick();
        s  = gnt_port_q.size();
        reset = 1'b0;
        r0 = cyc;
        repeat (13) tick();
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) tick();
        check("t3_gnt_count_ge4", 32'(gnt_port_q.size() - s >= 4), 32'd1);
        if (gnt_port_q.size() - s >= 4) begin
            check("t3_order0", 32'(gnt_port_q[s]),   32'd0);
            check("t3_order1", 32'(gnt_port_q[s+1]), 32'd1);
            check("t3_order2", 32'(gnt_port_q[s+2]), 32'd0);
            check("t3_order3", 32'(gnt_port_q[s+3]), 32'd1);
            check("t3_first_lat", 32'(gnt_cyc_q[s] - r0), 32'd1);
            for (int k = 0; k < 3; k++)
                check("t3_gap", 32'(gnt_cyc_q[s+k+1] - gnt_cyc_q[s+k]), 32'd3);
            $display("txn rr grants: %0d@%0d %0d@%0d %0d@%0d %0d@%0d",
                     gnt_port_q[s], gnt_cyc_q[s], gnt_port_q[s+1], gnt_cyc_q[s+1],
                     gnt_port_q[s+2], gnt_cyc_q[s+2], gnt_port_q[s+3], gnt_cyc_q[s+3]);
        end

        // Misaligned LS write
        we0 = we_count;
        do_req(1'b1, 1'b1, 32'h13, 32'hAAAAAAAA, rd, er, gl, rl);
        check("t4_err", 32'(er), 32'd1);
        check("t4_rdata", rd, 32'h0);
        check("t4_gnt_lat", 32'(gl), 32'd1);
        check("t4_no_we", 32'(we_count - we0), 32'd0);
        check("t4_word10", mem[4], 32'h12345678);

        // Reset during ACCESS of an LS write to 0x20
        we0 = we_count;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h55555555;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_gnt_in_access", 32'(ls_gnt), 32'd1);
        check("t5_we_gated", 32'(mem_we), 32'd0);
        tick();
        reset = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        check("t5_ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("t5_ls_gnt", 32'(ls_gnt), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd0);
        check("t5_mem_addr", mem_addr, 32'h0);
        check("t5_mem_wdata", mem_wdata, 32'h0);
        check("t5_ls_rdata", ls_rdata, 32'h0);
        tick();
        repeat (2) tick();
        check("t5_word20", mem[8], 32'hCAFEF00D);
        check("t5_no_we", 32'(we_count - we0), 32'd0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, rd, er, gl, rl);
        check("t5_idle_gnt_lat", 32'(gl), 32'd1);
        check("t5_readback", rd, 32'hCAFEF00D);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified byte-addressed data memory between the instruction-fetch unit (IF port) and the load/store unit (LS port). It sits between the core and the memory: it accepts requests, picks one per access with round-robin priority, and sequences the memory through a 3-state FSM. It returns read data or write acknowledgement with a registered response, and rejects misaligned word accesses without touching memory.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width (one word = 4 bytes)
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF read request; held with if_addr until if_gnt
- if_addr  in  AW  IF byte address
- if_gnt  out  1  one-cycle pulse: IF request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata/if_err valid
- if_rdata  out  DW  IF read data
- if_err  out  1  misaligned-address error, qualified by if_rvalid
- ls_req  in  1  LS request; held with ls_we/ls_addr/ls_wdata until ls_gnt
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  AW  LS byte address
- ls_wdata  in  DW  LS write data
- ls_gnt  out  1  one-cycle pulse: LS request accepted
- ls_rvalid  out  1  one-cycle pulse: read data or write ack valid
- ls_rdata  out  DW  LS read data (0 for writes)
- ls_err  out  1  misaligned-address error, qualified by ls_rvalid
- mem_we  out  1  memory write enable; write commits at posedge
- mem_addr  out  AW  memory byte address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- IDLE: if any req is high, arbitrate and latch the winner's port, addr, we and wdata into registers, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive mem_addr and mem_wdata from the registers. Assert the winner's gnt. Assert mem_we = latched_we & aligned & !reset. Capture mem_rdata into the response register (0 if a write or misaligned). Go to RESP.
- RESP: assert the winner's rvalid with rdata and err. All reqs are ignored in this state. Go to IDLE.
- Arbitration: if only one port requests, that port wins. If both request, the port not granted last wins. The last-grant register resets to LS, so IF wins the first tie. The register updates only on the IDLE→ACCESS transition.
- The IF port never writes; its requests are always reads.
- Aligned means addr[1:0] == 2'b00. A misaligned access still completes the full handshake with gnt, then rvalid with err=1 and rdata=0. mem_we stays 0 for it.
- When no access is in progress, mem_addr, mem_wdata and mem_we are 0.

## Timing
- Reset values: all gnt, rvalid, err and mem_we = 0; rdata, mem_addr and mem_wdata = 0; state = IDLE; last grant = LS.
- Latency: req sampled in cycle 0 (IDLE), gnt in cycle 1 (ACCESS), rvalid in cycle 2 (RESP). A write commits at the posedge ending cycle 1.
- Throughput: one access per 3 cycles. The earliest next acceptance is the IDLE cycle after RESP.
- A requester drops req, or presents a new request, in the cycle after gnt. A req still high in the next IDLE cycle is treated as a new access.
- The losing requester holds req; it is served in the next arbitration round. Continuous requests from both ports therefore alternate IF, LS, IF, …
- Reset asserted in ACCESS or RESP: the FSM goes to IDLE at that edge, any pending rvalid is dropped, and a write in flight does not commit because mem_we is gated by reset.

## Structure
- Package mem_arb_pkg holds:
  - state_e {IDLE, ACCESS, RESP}
  - port_e {PORT_IF, PORT_LS}
  - the alignment mask constant
- Sub-module rr_arbiter2 contains the two-requester round-robin pick and the last-grant register, with an advance input pulsed on IDLE→ACCESS.
- The top level contains the FSM, request latch and response registers.

## Test plan
- IF-only read, if_addr=0x8, memory word 0x8 = 0xDEADBEEF → if_gnt in cycle 1, if_rvalid in cycle 2 with if_rdata=0xDEADBEEF and if_err=0.
- LS write 0x12345678 to 0x10, then LS read of 0x10 → write: mem_we high exactly one cycle with mem_addr=0x10 and ls_rvalid with ls_rdata=0. Read: ls_rdata=0x12345678.
- Both ports requesting continuously from reset → grant order IF, LS, IF, LS, with 3 cycles between successive gnts.
- LS write to misaligned 0x13 → ls_gnt, then ls_rvalid with ls_err=1 and ls_rdata=0. mem_we never rises, and word 0x10 is unchanged.
- Reset asserted during ACCESS of an LS write to 0x20 → no ls_rvalid, word 0x20 is unchanged, all outputs are 0 on the next cycle, and the FSM is in IDLE.
